// File: rtl/quad_enc_pkg.sv
// rtl/quad_enc_pkg.sv - shared phase encodings and widths for the rotary encoder front end
package quad_enc_pkg;

  typedef enum logic [1:0] {
    PH_00 = 2'b00,
    PH_01 = 2'b01,
    PH_11 = 2'b11,
    PH_10 = 2'b10
  } phase_t;

  // Sub-step accumulator is one bit wider than three so that +4 is representable.
  localparam int ACC_W = 4;
  localparam logic signed [ACC_W-1:0] ACC_ONE    = 4'sd1;
  localparam logic signed [ACC_W-1:0] ACC_DET_UP = 4'sd4;
  localparam logic signed [ACC_W-1:0] ACC_DET_DN = -4'sd4;

  localparam int VAL_W = 8;

  function automatic phase_t ph_up_next(input phase_t ph);
    case (ph)
      PH_00:   return PH_01;
      PH_01:   return PH_11;
      PH_11:   return PH_10;
      default: return PH_00;
    endcase
  endfunction

endpackage

// File: rtl/enc_debounce.sv
// rtl/enc_debounce.sv - 2-flop synchroniser plus sample-count debounce for one encoder input
module enc_debounce #(
  parameter int   DEB_SAMPLES = 8,
  parameter logic RST_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic smp_en,
  input  logic din,
  output logic dout
);

  logic [1:0] sync;
  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= {2{RST_LEVEL}};
      cnt  <= '0;
      dout <= RST_LEVEL;
    end else begin
      sync <= {sync[0], din};
      if (smp_en) begin
        if (sync[1] == dout) begin
          cnt <= '0;
        end else if (cnt == 8'(DEB_SAMPLES - 1)) begin
          dout <= ~dout;
          cnt  <= '0;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/quad_enc_accel.sv
// rtl/quad_enc_accel.sv - debounced quadrature decoder with accelerated, clamped 8-bit rate value
module quad_enc_accel
  import quad_enc_pkg::*;
#(
  parameter int DEB_SAMPLES  = 8,
  parameter int ACCEL_WINDOW = 32,
  parameter int ACCEL_STEP   = 4,
  parameter int VAL_RESET    = 8,
  parameter int VAL_MIN      = 1,
  parameter int VAL_MAX      = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             smp_en,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             enc_btn_n,
  output logic [VAL_W-1:0] value,
  output logic             tick,
  output logic             dir,
  output logic             quad_err
);

  logic                    a_db, b_db, btn_db, btn_q;
  phase_t                  ph, ph_q;
  logic signed [ACC_W-1:0] acc, acc_nxt;
  logic [7:0]              gap;
  logic                    illegal, det_up, det_dn, press;
  logic [VAL_W-1:0]        delta, up_val, dn_val;
  logic [VAL_W:0]          sum, diff;

  enc_debounce #(.DEB_SAMPLES(DEB_SAMPLES), .RST_LEVEL(1'b0)) u_deb_a (
    .clk(clk), .rst(rst), .smp_en(smp_en), .din(enc_a), .dout(a_db));
  enc_debounce #(.DEB_SAMPLES(DEB_SAMPLES), .RST_LEVEL(1'b0)) u_deb_b (
    .clk(clk), .rst(rst), .smp_en(smp_en), .din(enc_b), .dout(b_db));
  enc_debounce #(.DEB_SAMPLES(DEB_SAMPLES), .RST_LEVEL(1'b1)) u_deb_btn (
    .clk(clk), .rst(rst), .smp_en(smp_en), .din(enc_btn_n), .dout(btn_db));

  assign ph    = phase_t'({a_db, b_db});
  assign press = btn_q & ~btn_db;

  // Decode one debounced phase move per clk; a detent is judged on arrival at 00.
  always_comb begin
    acc_nxt = acc;
    illegal = 1'b0;
    det_up  = 1'b0;
    det_dn  = 1'b0;
    if (ph != ph_q) begin
      if ((ph ^ ph_q) == 2'b11) begin
        illegal = 1'b1;
      end else if (ph == ph_up_next(ph_q)) begin
        if (acc != ACC_DET_UP) acc_nxt = acc + ACC_ONE;
      end else begin
        if (acc != ACC_DET_DN) acc_nxt = acc - ACC_ONE;
      end
      if (ph == PH_00) begin
        det_up  = (acc_nxt == ACC_DET_UP);
        det_dn  = (acc_nxt == ACC_DET_DN);
        acc_nxt = '0;
      end
    end
  end

  always_comb begin
    delta  = (gap < 8'(ACCEL_WINDOW)) ? VAL_W'(ACCEL_STEP) : VAL_W'(1);
    sum    = {1'b0, value} + {1'b0, delta};
    diff   = {1'b0, value} - {1'b0, delta};
    up_val = (sum > (VAL_W+1)'(VAL_MAX)) ? VAL_W'(VAL_MAX) : sum[VAL_W-1:0];
    dn_val = (diff[VAL_W] || diff < (VAL_W+1)'(VAL_MIN)) ? VAL_W'(VAL_MIN) : diff[VAL_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph_q     <= PH_00;
      acc      <= '0;
      gap      <= 8'(ACCEL_WINDOW);
      btn_q    <= 1'b1;
      value    <= VAL_W'(VAL_RESET);
      tick     <= 1'b0;
      dir      <= 1'b0;
      quad_err <= 1'b0;
    end else begin
      ph_q  <= ph;
      acc   <= acc_nxt;
      btn_q <= btn_db;
      tick  <= press | det_up | det_dn;
      if (illegal) quad_err <= 1'b1;
      // A button press swallows a coincident detent, including its gap restart.
      if (press) begin
        value <= VAL_W'(VAL_RESET);
      end else if (det_up) begin
        value <= up_val;
        dir   <= 1'b1;
      end else if (det_dn) begin
        value <= dn_val;
        dir   <= 1'b0;
      end
      if (!press && (det_up || det_dn)) gap <= '0;
      else if (smp_en && gap < 8'(ACCEL_WINDOW)) gap <= gap + 8'd1;
    end
  end

endmodule

// File: tb/tb_quad_enc_accel.sv
// tb/tb_quad_enc_accel.sv - self-checking bench for quad_enc_accel against a detent-level model
module tb_quad_enc_accel;

  localparam int DEB = 4, AW = 32, STEP = 4, VRST = 8, VMIN = 1, VMAX = 255;

  logic       clk = 1'b0, rst = 1'b0, smp_en = 1'b0;
  logic       enc_a = 1'b0, enc_b = 1'b0, enc_btn_n = 1'b1;
  logic [7:0] value;
  logic       tick, dir, quad_err;

  int n_tests = 0, n_fail = 0, tick_cnt = 0, strobe_idx = 0;
  int last_det = -1000, m_val = VRST;
  bit m_dir = 1'b0;

  quad_enc_accel #(
    .DEB_SAMPLES(DEB), .ACCEL_WINDOW(AW), .ACCEL_STEP(STEP),
    .VAL_RESET(VRST), .VAL_MIN(VMIN), .VAL_MAX(VMAX)
  ) dut (
    .clk(clk), .rst(rst), .smp_en(smp_en), .enc_a(enc_a), .enc_b(enc_b),
    .enc_btn_n(enc_btn_n), .value(value), .tick(tick), .dir(dir), .quad_err(quad_err)
  );

  always #5 clk = ~clk;
  always @(negedge clk) smp_en <= ~smp_en;
  always @(negedge clk) if (tick === 1'b1) tick_cnt <= tick_cnt + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic int step_val(input int v, input bit up, input bit fast);
    int d;
    d = fast ? STEP : 1;
    if (up) return (v + d > VMAX) ? VMAX : v + d;
    return (v - d < VMIN) ? VMIN : v - d;
  endfunction

  task automatic wait_strobes(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!smp_en) @(posedge clk);
    end
    strobe_idx += n;
    #1;
  endtask

  task automatic set_ph(input logic [1:0] ph, input int h);
    {enc_a, enc_b} = ph;
    wait_strobes(h);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    {enc_a, enc_b} = 2'b00;
    enc_btn_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    m_val = VRST; m_dir = 1'b0; last_det = -1000;
    wait_strobes(10);
  endtask

  // Full detent; detents closer than AW strobes (final-phase to final-phase) are fast.
  task automatic turn(input bit up, input int h);
    int s;
    bit fast;
    if (up) begin set_ph(2'b01, h); set_ph(2'b11, h); set_ph(2'b10, h); end
    else    begin set_ph(2'b10, h); set_ph(2'b11, h); set_ph(2'b01, h); end
    s = strobe_idx;
    fast = (s - last_det) < AW;
    last_det = s;
    m_val = step_val(m_val, up, fast);
    m_dir = up;
    set_ph(2'b00, 7);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (value !== 8'(VRST)) begin n_fail++; $display("FAIL reset_value: got %0d expected %0d", value, VRST); end
    n_tests++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b expected 0", tick); end
    n_tests++; if (dir !== 1'b0) begin n_fail++; $display("FAIL reset_dir: got %b expected 0", dir); end
    n_tests++; if (quad_err !== 1'b0) begin n_fail++; $display("FAIL reset_quad_err: got %b expected 0", quad_err); end
    do_reset();
  endtask

  task automatic test_up_detent();
    int t0;
    t0 = tick_cnt;
    turn(1'b1, 20);
    n_tests++; if (value !== 8'd9) begin n_fail++; $display("FAIL up_value: got %0d expected 9", value); end
    n_tests++; if (tick_cnt - t0 != 1) begin n_fail++; $display("FAIL up_ticks: got %0d expected 1", tick_cnt - t0); end
    n_tests++; if (dir !== 1'b1) begin n_fail++; $display("FAIL up_dir: got %b expected 1", dir); end
    n_tests++; if (quad_err !== 1'b0) begin n_fail++; $display("FAIL up_quad_err: got %b expected 0", quad_err); end
  endtask

  task automatic test_down_accel();
    int t0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      turn(1'b0, 25);
      n_tests++; if (value !== 8'(7 - i)) begin n_fail++; $display("FAIL slow_down_%0d: got %0d expected %0d", i, value, 7 - i); end
    end
    t0 = tick_cnt;
    for (int i = 0; i < 3; i++) begin
      turn(1'b0, 5);
      n_tests++; if (value !== 8'(m_val)) begin n_fail++; $display("FAIL fast_down_%0d: got %0d expected %0d", i, value, m_val); end
    end
    n_tests++; if (value !== 8'(VMIN)) begin n_fail++; $display("FAIL fast_down_clamp: got %0d expected %0d", value, VMIN); end
    n_tests++; if (tick_cnt - t0 != 3) begin n_fail++; $display("FAIL fast_down_ticks: got %0d expected 3", tick_cnt - t0); end
    n_tests++; if (dir !== 1'b0) begin n_fail++; $display("FAIL fast_down_dir: got %b expected 0", dir); end
  endtask

  task automatic test_clamp_max();
    int t0;
    do_reset();
    turn(1'b1, 25);
    for (int i = 0; i < 61; i++) turn(1'b1, 5);
    n_tests++; if (value !== 8'd253) begin n_fail++; $display("FAIL climb_value: got %0d expected 253", value); end
    t0 = tick_cnt;
    turn(1'b1, 5);
    n_tests++; if (value !== 8'd255) begin n_fail++; $display("FAIL clamp_first: got %0d expected 255", value); end
    turn(1'b1, 5);
    n_tests++; if (value !== 8'd255) begin n_fail++; $display("FAIL clamp_second: got %0d expected 255", value); end
    n_tests++; if (tick_cnt - t0 != 2) begin n_fail++; $display("FAIL clamp_ticks: got %0d expected 2", tick_cnt - t0); end
  endtask

  task automatic test_glitch_half_turn();
    int t0;
    t0 = tick_cnt;
    for (int i = 0; i < 8; i++) begin
      enc_a = 1'b1;
      wait_strobes($urandom_range(1, DEB - 2));
      enc_a = 1'b0;
      wait_strobes($urandom_range(3, 6));
    end
    set_ph(2'b01, 10);
    set_ph(2'b00, 10);
    n_tests++; if (tick_cnt != t0) begin n_fail++; $display("FAIL glitch_ticks: got %0d expected %0d", tick_cnt, t0); end
    n_tests++; if (value !== 8'(m_val)) begin n_fail++; $display("FAIL glitch_value: got %0d expected %0d", value, m_val); end
    n_tests++; if (quad_err !== 1'b0) begin n_fail++; $display("FAIL glitch_quad_err: got %b expected 0", quad_err); end
  endtask

  task automatic test_button();
    int t0;
    do_reset();
    turn(1'b1, 25);
    turn(1'b1, 25);
    turn(1'b0, 25);
    n_tests++; if (value !== 8'(m_val)) begin n_fail++; $display("FAIL btn_pre_value: got %0d expected %0d", value, m_val); end
    t0 = tick_cnt;
    set_ph(2'b01, 20); set_ph(2'b11, 20); set_ph(2'b10, 20);
    {enc_a, enc_b} = 2'b00;
    enc_btn_n = 1'b0;
    m_val = VRST;
    wait_strobes(20);
    n_tests++; if (value !== 8'(VRST)) begin n_fail++; $display("FAIL btn_value: got %0d expected %0d", value, VRST); end
    n_tests++; if (tick_cnt - t0 != 1) begin n_fail++; $display("FAIL btn_ticks: got %0d expected 1", tick_cnt - t0); end
    n_tests++; if (dir !== m_dir) begin n_fail++; $display("FAIL btn_dir: got %b expected %b", dir, m_dir); end
    wait_strobes(1000);
    enc_btn_n = 1'b1;
    wait_strobes(20);
    n_tests++; if (tick_cnt - t0 != 1) begin n_fail++; $display("FAIL btn_hold_ticks: got %0d expected 1", tick_cnt - t0); end
    n_tests++; if (value !== 8'(VRST)) begin n_fail++; $display("FAIL btn_hold_value: got %0d expected %0d", value, VRST); end
  endtask

  task automatic test_reset_mid_detent();
    int t0;
    turn(1'b0, 25);
    set_ph(2'b10, 10);
    set_ph(2'b11, 10);
    #2 rst = 1'b0;
    #1;
    n_tests++; if (value !== 8'(VRST)) begin n_fail++; $display("FAIL rstmid_value: got %0d expected %0d", value, VRST); end
    n_tests++; if (dir !== 1'b0) begin n_fail++; $display("FAIL rstmid_dir: got %b expected 0", dir); end
    {enc_a, enc_b} = 2'b00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    m_val = VRST; m_dir = 1'b0; last_det = -1000;
    t0 = tick_cnt;
    wait_strobes(30);
    n_tests++; if (tick_cnt != t0) begin n_fail++; $display("FAIL rstmid_ticks: got %0d expected %0d", tick_cnt, t0); end
    n_tests++; if (quad_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_quad_err: got %b expected 0", quad_err); end
  endtask

  task automatic test_random();
    int t0, h;
    bit up, fast;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      up   = 1'($urandom % 2);
      fast = ($urandom % 3) != 0;
      h    = fast ? 5 : $urandom_range(10, 30);
      t0   = tick_cnt;
      turn(up, h);
      n_tests++; if (value !== 8'(m_val)) begin n_fail++; $display("FAIL rand_value_%0d: got %0d expected %0d", i, value, m_val); end
      n_tests++; if (dir !== m_dir) begin n_fail++; $display("FAIL rand_dir_%0d: got %b expected %b", i, dir, m_dir); end
      n_tests++; if (tick_cnt - t0 != 1) begin n_fail++; $display("FAIL rand_ticks_%0d: got %0d expected 1", i, tick_cnt - t0); end
    end
  endtask

  task automatic test_quad_err();
    int t0;
    t0 = tick_cnt;
    set_ph(2'b11, 20);
    n_tests++; if (quad_err !== 1'b1) begin n_fail++; $display("FAIL qerr_set: got %b expected 1", quad_err); end
    set_ph(2'b00, 20);
    n_tests++; if (quad_err !== 1'b1) begin n_fail++; $display("FAIL qerr_sticky: got %b expected 1", quad_err); end
    n_tests++; if (value !== 8'(m_val)) begin n_fail++; $display("FAIL qerr_value: got %0d expected %0d", value, m_val); end
    n_tests++; if (tick_cnt != t0) begin n_fail++; $display("FAIL qerr_ticks: got %0d expected %0d", tick_cnt, t0); end
    turn(1'b1, 25);
    n_tests++; if (value !== 8'(m_val)) begin n_fail++; $display("FAIL qerr_after_value: got %0d expected %0d", value, m_val); end
    n_tests++; if (quad_err !== 1'b1) begin n_fail++; $display("FAIL qerr_after_sticky: got %b expected 1", quad_err); end
  endtask

  initial begin
    test_reset();
    test_up_detent();
    test_down_accel();
    test_clamp_max();
    test_glitch_half_turn();
    test_button();
    test_reset_mid_detent();
    test_random();
    test_quad_err();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
